// File: rtl/s2_pkg.sv
// s2_pkg: states and sizing constants shared by the stage-2 controller and result collector
package s2_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  localparam int N_DIR  = 4;
  localparam int N_ADDR = 36;
  localparam int N_PROD = N_DIR * N_ADDR;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 16;
endpackage

// File: rtl/s2_sat_relu.sv
// s2_sat_relu: clamps a signed accumulator into the signed result range, optional ReLU
module s2_sat_relu #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    relu_en_i,
  output logic signed [OUT_W-1:0] res_o
);
  localparam logic signed [OUT_W-1:0] MAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_O = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_O);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_O);
  always_comb
    res_o = (relu_en_i && acc_i[ACC_W-1]) ? '0 :
            (acc_i > MAX_V) ? MAX_O :
            (acc_i < MIN_V) ? MIN_O : acc_i[OUT_W-1:0];
endmodule

// File: rtl/s2_result_collector.sv
// s2_result_collector: sums stage-2 products into four kernel accumulators and streams saturated results
module s2_result_collector #(
  parameter int DATA_W = s2_pkg::DATA_W,
  parameter int ACC_W  = s2_pkg::ACC_W,
  parameter int OUT_W  = s2_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prod_valid,
  input  logic signed [DATA_W-1:0] prod_data,
  input  logic [1:0]               prod_dir,
  input  logic                     relu_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic [1:0]               out_idx,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);
  import s2_pkg::*;
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [N_DIR];
  logic signed [ACC_W-1:0] acc_d [N_DIR];
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic relu_q, relu_d, done_q, done_d, ovr_q, ovr_d;
  logic signed [OUT_W-1:0] sat;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    relu_d  = relu_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (state_q != OUT && prod_valid) begin
      acc_d[prod_dir] = acc_q[prod_dir] + ACC_W'(prod_data);
      cnt_d   = cnt_q + 8'd1;
      state_d = (cnt_q == 8'(N_PROD-1)) ? OUT : ACCUM;
      relu_d  = (cnt_q == 8'(N_PROD-1)) ? relu_en : relu_q;
    end
    if (state_q == OUT) begin
      ovr_d = ovr_q | prod_valid;
      if (out_ready) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(N_DIR-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '{default: '0};
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '{default: '0};
      cnt_q   <= '0;
      idx_q   <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  s2_sat_relu #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .acc_i(acc_q[idx_q]),
    .relu_en_i(relu_q),
    .res_o(sat)
  );
  assign out_valid  = state_q == OUT;
  assign busy       = state_q != IDLE;
  assign out_data   = out_valid ? sat : '0;
  assign out_idx    = idx_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
endmodule
